// File: rtl/mem_access_unit_pkg.sv
// Shared types and helpers for the load/store access unit.
package mem_access_unit_pkg;

  typedef logic [31:0] rvwordT;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } memsizeT;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_DATA,
    WR,
    ERR
  } lsu_stateT;

  // Encoding of req_size that has no memsizeT member.
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // True when a byte address is not naturally aligned for the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus data-memory port of the access unit.
// The slave modport is the unit; the master modport is the core and memory side.
interface mem_access_unit_if;
  import mem_access_unit_pkg::*;

  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_size;
  logic       req_unsigned;
  rvwordT     req_addr;
  rvwordT     req_wdata;
  logic       resp_valid;
  logic       resp_err;
  rvwordT     resp_rdata;
  logic       dwe;
  rvwordT     daddr;
  rvwordT     ddatain;
  rvwordT     ddataout;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ddataout,
    output req_ready, resp_valid, resp_err, resp_rdata, dwe, daddr, ddatain
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ddataout,
    input  req_ready, resp_valid, resp_err, resp_rdata, dwe, daddr, ddatain
  );

endinterface

// File: rtl/mem_access_unit_align.sv
// Little-endian lane steering: extracts and extends a load lane from a memory
// word, and merges sub-word store data into a memory word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  rvwordT     word,
  input  logic [1:0] lane,
  input  memsizeT    size,
  input  logic       is_unsigned,
  input  rvwordT     wdata,
  output rvwordT     load_val,
  output rvwordT     merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, extend it for loads and splice it for stores.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any branch, so no path leaves it unassigned and no latch is inferred.
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    load_val = word;
    merged   = wdata;
    case (size)
      MEM_B: begin
        load_val = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        merged   = word;
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      MEM_H: begin
        load_val = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        merged   = word;
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        load_val = word;
        merged   = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator with alignment/range checking and
// read-modify-write for byte and halfword stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_WIDTH = 16
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  lsu_stateT state, state_next;
  logic      we_q, uns_q;
  memsizeT   size_q;
  rvwordT    addr_q, wdata_q, merged_q;
  rvwordT    load_val, merged_word;
  rvwordT    req_index, addr_index;
  logic      accept, req_bad;

  assign accept     = bus.req_valid && bus.req_ready;
  assign req_index  = {2'b00, bus.req_addr[31:2]};
  assign addr_index = {2'b00, addr_q[31:2]};

  // Classify the incoming request: illegal size, misaligned, or beyond the memory.
  always_comb begin
    req_bad = (bus.req_size == SIZE_ILLEGAL)
           || is_misaligned(bus.req_size, bus.req_addr[1:0])
           || ((req_index >> MEM_WIDTH) != '0);
  end

  mem_lane_align u_align (
    .word        (bus.ddataout),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .load_val    (load_val),
    .merged      (merged_word)
  );

  // State register, latched request fields and the read-modify-write merge buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the latched request and merge buffer are reset too; they are a few flops and this keeps outputs defined straight out of reset.
      state    <= IDLE;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= MEM_B;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= memsizeT'(bus.req_size);
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state == RD_DATA && we_q) merged_q <= merged_word;
    end
  end

  // Next-state decode and outputs driven from the current state and latched fields.
  always_comb begin
    state_next     = state;
    bus.req_ready  = (state == IDLE) && !rst;
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.dwe        = 1'b0;
    bus.daddr      = '0;
    bus.ddatain    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_bad)                                  state_next = ERR;
          else if (bus.req_we && bus.req_size == MEM_W) state_next = WR;
          else                                          state_next = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        bus.daddr  = addr_index;
        state_next = RD_DATA;
      end
      RD_DATA: begin
        bus.daddr = addr_index;
        if (we_q) begin
          state_next = WR;
        end else begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = load_val;
          state_next     = IDLE;
        end
      end
      WR: begin
        bus.dwe        = 1'b1;
        bus.daddr      = addr_index;
        bus.ddatain    = (size_q == MEM_W) ? wdata_q : merged_q;
        bus.resp_valid = 1'b1;
        state_next     = IDLE;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural registered memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  typedef struct {
    int         cyc;
    logic       err;
    rvwordT     rdata;
    logic [7:0] dmask;
    rvwordT     wdata;
    rvwordT     idx1;
    rvwordT     idx3;
    logic       ready_busy;
  } xact_t;

  typedef struct {
    logic       we;
    logic [1:0] size;
    logic       uns;
    rvwordT     addr;
    rvwordT     wdata;
    int         cyc;
    logic       err;
    rvwordT     rdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  xact_t sb_q[$];

  always #5 clk = ~clk;

  mem_access_unit_if bus();

  mem_access_unit #(.MEM_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rvwordT mem [0:65535];

  always @(posedge clk) begin
    if (bus.dwe) mem[bus.daddr[15:0]] <= bus.ddatain;
    bus.ddataout <= mem[bus.daddr[15:0]];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input rvwordT addr, input rvwordT wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic collect(output xact_t o);
    o.cyc = -1; o.err = 1'b0; o.rdata = '0; o.dmask = '0;
    o.wdata = '0; o.idx1 = '0; o.idx3 = '0; o.ready_busy = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (bus.dwe) begin
        o.dmask[c] = 1'b1;
        o.wdata    = bus.ddatain;
      end
      if (bus.req_ready) o.ready_busy = 1'b1;
      if (c == 1) o.idx1 = bus.daddr;
      if (c == 3) o.idx3 = bus.daddr;
      if (bus.resp_valid) begin
        o.cyc   = c;
        o.err   = bus.resp_err;
        o.rdata = bus.resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dwe, bus.resp_valid, bus.resp_err, bus.req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: dwe/rv/err/ready got %b want 0000",
               {bus.dwe, bus.resp_valid, bus.resp_err, bus.req_ready});
    end
    checks++;
    if (bus.daddr !== 32'h0) begin errors++; $display("FAIL reset_daddr: got %h want 0", bus.daddr); end
    checks++;
    if (bus.ddatain !== 32'h0) begin errors++; $display("FAIL reset_ddatain: got %h want 0", bus.ddatain); end
    checks++;
    if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata); end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.req_ready); end
  endtask

  // Loads and error requests: response cycle, error flag, data, and no writes.
  task automatic run_vectors(input string tag, input vec_t v[]);
    xact_t e, o;
    foreach (v[i]) begin
      e = '{cyc: v[i].cyc, err: v[i].err, rdata: v[i].rdata, dmask: 8'h00,
            wdata: 32'h0, idx1: 32'h0, idx3: 32'h0, ready_busy: 1'b0};
      sb_q.push_back(e);
      issue(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata);
      collect(o);
      e = sb_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc) begin errors++; $display("FAIL %s[%0d] resp_cycle: got %0d want %0d", tag, i, o.cyc, e.cyc); end
      checks++;
      if (o.err !== e.err) begin errors++; $display("FAIL %s[%0d] resp_err: got %b want %b", tag, i, o.err, e.err); end
      checks++;
      if (o.rdata !== e.rdata) begin errors++; $display("FAIL %s[%0d] resp_rdata: got %h want %h", tag, i, o.rdata, e.rdata); end
      checks++;
      if (o.dmask !== e.dmask) begin errors++; $display("FAIL %s[%0d] dwe_cycles: got %b want %b", tag, i, o.dmask, e.dmask); end
    end
  endtask

  task automatic test_loads;
    vec_t v[];
    v = new[8];
    v[0] = '{1'b0, 2'b00, 1'b0, 32'h401,   32'h0, 2, 1'b0, 32'hFFFFFFAA};
    v[1] = '{1'b0, 2'b01, 1'b1, 32'h402,   32'h0, 2, 1'b0, 32'h00008899};
    v[2] = '{1'b0, 2'b01, 1'b0, 32'h402,   32'h0, 2, 1'b0, 32'hFFFF8899};
    v[3] = '{1'b0, 2'b00, 1'b1, 32'h403,   32'h0, 2, 1'b0, 32'h00000088};
    v[4] = '{1'b0, 2'b00, 1'b0, 32'h400,   32'h0, 2, 1'b0, 32'hFFFFFFBB};
    v[5] = '{1'b0, 2'b10, 1'b1, 32'h400,   32'h0, 2, 1'b0, 32'h8899AABB};
    v[6] = '{1'b0, 2'b10, 1'b0, 32'h3FFFC, 32'h0, 2, 1'b0, 32'hCAFEF00D};
    v[7] = '{1'b0, 2'b01, 1'b0, 32'h3FFFC, 32'h0, 2, 1'b0, 32'hFFFFF00D};
    run_vectors("load", v);
  endtask

  task automatic test_errors;
    vec_t v[];
    v = new[5];
    v[0] = '{1'b0, 2'b01, 1'b0, 32'h401,   32'h0,        1, 1'b1, 32'h0};
    v[1] = '{1'b1, 2'b10, 1'b0, 32'h402,   32'hDEADBEEF, 1, 1'b1, 32'h0};
    v[2] = '{1'b0, 2'b11, 1'b0, 32'h400,   32'h0,        1, 1'b1, 32'h0};
    v[3] = '{1'b0, 2'b10, 1'b0, 32'h40000, 32'h0,        1, 1'b1, 32'h0};
    v[4] = '{1'b1, 2'b00, 1'b0, 32'h40000, 32'h11,       1, 1'b1, 32'h0};
    run_vectors("error", v);
    checks++;
    if (mem[16'h100] !== 32'h8899AABB) begin errors++; $display("FAIL error_mem_untouched: got %h want 8899aabb", mem[16'h100]); end
  endtask

  task automatic test_sub_store;
    xact_t e, o;
    vec_t v[];
    e = '{cyc: 3, err: 1'b0, rdata: 32'h0, dmask: 8'b0000_1000,
          wdata: 32'h5599AABB, idx1: 32'h100, idx3: 32'h100, ready_busy: 1'b0};
    sb_q.push_back(e);
    issue(1'b1, 2'b00, 1'b0, 32'h403, 32'hABCDEF55);
    collect(o);
    e = sb_q.pop_front();
    checks++;
    if (o.cyc !== e.cyc) begin errors++; $display("FAIL byte_store resp_cycle: got %0d want %0d", o.cyc, e.cyc); end
    checks++;
    if (o.err !== e.err) begin errors++; $display("FAIL byte_store resp_err: got %b want %b", o.err, e.err); end
    checks++;
    if (o.dmask !== e.dmask) begin errors++; $display("FAIL byte_store dwe_cycles: got %b want %b", o.dmask, e.dmask); end
    checks++;
    if (o.wdata !== e.wdata) begin errors++; $display("FAIL byte_store ddatain: got %h want %h", o.wdata, e.wdata); end
    checks++;
    if (o.idx1 !== e.idx1 || o.idx3 !== e.idx3) begin
      errors++; $display("FAIL byte_store daddr: got %h/%h want %h/%h", o.idx1, o.idx3, e.idx1, e.idx3);
    end
    checks++;
    if (o.rdata !== e.rdata) begin errors++; $display("FAIL byte_store resp_rdata: got %h want 0", o.rdata); end
    v = new[1];
    v[0] = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 2, 1'b0, 32'h5599AABB};
    run_vectors("after_byte_store", v);
  endtask

  task automatic test_word_store;
    xact_t e, o;
    vec_t v[];
    e = '{cyc: 1, err: 1'b0, rdata: 32'h0, dmask: 8'b0000_0010,
          wdata: 32'h12345678, idx1: 32'h101, idx3: 32'h0, ready_busy: 1'b0};
    sb_q.push_back(e);
    issue(1'b1, 2'b10, 1'b1, 32'h404, 32'h12345678);
    collect(o);
    e = sb_q.pop_front();
    checks++;
    if (o.cyc !== e.cyc) begin errors++; $display("FAIL word_store resp_cycle: got %0d want %0d", o.cyc, e.cyc); end
    checks++;
    if (o.dmask !== e.dmask) begin errors++; $display("FAIL word_store dwe_cycles: got %b want %b", o.dmask, e.dmask); end
    checks++;
    if (o.wdata !== e.wdata) begin errors++; $display("FAIL word_store ddatain: got %h want %h", o.wdata, e.wdata); end
    checks++;
    if (o.idx1 !== e.idx1) begin errors++; $display("FAIL word_store daddr: got %h want %h", o.idx1, e.idx1); end
    checks++;
    if (o.err !== e.err) begin errors++; $display("FAIL word_store resp_err: got %b want %b", o.err, e.err); end
    v = new[2];
    v[0] = '{1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 2, 1'b0, 32'h12345678};
    v[1] = '{1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 2, 1'b0, 32'hFFFFFFBB};
    run_vectors("after_word_store", v);
  endtask

  task automatic test_back_to_back;
    xact_t e, o;
    e = '{cyc: 3, err: 1'b0, rdata: 32'h0, dmask: 8'b0000_1000,
          wdata: 32'h5599BEEF, idx1: 32'h100, idx3: 32'h100, ready_busy: 1'b0};
    sb_q.push_back(e);
    e = '{cyc: 2, err: 1'b0, rdata: 32'h5599BEEF, dmask: 8'h00,
          wdata: 32'h0, idx1: 32'h100, idx3: 32'h0, ready_busy: 1'b0};
    sb_q.push_back(e);
    issue(1'b1, 2'b01, 1'b0, 32'h400, 32'h0000BEEF);
    collect(o);
    e = sb_q.pop_front();
    checks++;
    if (o.cyc !== e.cyc || o.wdata !== e.wdata || o.dmask !== e.dmask) begin
      errors++; $display("FAIL half_store cyc/ddatain/dwe: got %0d/%h/%b want %0d/%h/%b",
                         o.cyc, o.wdata, o.dmask, e.cyc, e.wdata, e.dmask);
    end
    checks++;
    if (o.ready_busy !== 1'b0) begin errors++; $display("FAIL half_store ready_while_busy: got 1 want 0"); end
    #1;
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp_cycle: got %b want 0", bus.req_ready); end
    issue(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    collect(o);
    e = sb_q.pop_front();
    checks++;
    if (o.cyc !== e.cyc || o.rdata !== e.rdata) begin
      errors++; $display("FAIL b2b_load cyc/rdata: got %0d/%h want %0d/%h", o.cyc, o.rdata, e.cyc, e.rdata);
    end
    checks++;
    if (o.ready_busy !== 1'b0) begin errors++; $display("FAIL b2b_load ready_while_busy: got 1 want 0"); end
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_resp: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_reset_mid;
    logic saw_dwe, saw_resp;
    vec_t v[];
    saw_dwe = 1'b0; saw_resp = 1'b0;
    issue(1'b1, 2'b00, 1'b0, 32'h401, 32'h00000077);
    @(negedge clk);
    saw_dwe |= bus.dwe;
    @(negedge clk);
    saw_dwe |= bus.dwe;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.dwe, bus.resp_valid, bus.req_ready} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_outputs: dwe/rv/ready got %b want 000", {bus.dwe, bus.resp_valid, bus.req_ready});
    end
    repeat (2) begin
      @(negedge clk);
      saw_dwe |= bus.dwe;
      saw_resp |= bus.resp_valid;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", bus.req_ready); end
    repeat (4) begin
      @(negedge clk);
      saw_dwe |= bus.dwe;
      saw_resp |= bus.resp_valid;
    end
    checks++;
    if (saw_dwe !== 1'b0) begin errors++; $display("FAIL mid_reset_dwe: got 1 want 0"); end
    checks++;
    if (saw_resp !== 1'b0) begin errors++; $display("FAIL mid_reset_resp: got 1 want 0"); end
    checks++;
    if (mem[16'h100] !== 32'h5599BEEF) begin errors++; $display("FAIL mid_reset_mem: got %h want 5599beef", mem[16'h100]); end
    v = new[1];
    v[0] = '{1'b0, 2'b00, 1'b1, 32'h401, 32'h0, 2, 1'b0, 32'h000000BE};
    run_vectors("after_mid_reset", v);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    mem[16'h100]  = 32'h8899AABB;
    mem[16'hFFFF] = 32'hCAFEF00D;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    test_reset;
    test_loads;
    test_errors;
    test_sub_store;
    test_word_store;
    test_back_to_back;
    test_reset_mid;
    checks++;
    if (sb_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the core's execute stage and the data port of the word-addressed, single-cycle-registered memory. Takes one byte-addressed load or store at a time and checks alignment and range. Byte and halfword stores are done as read-modify-write. Loads return sign- or zero-extended data.

## Interface
Parameters:
- MEM_WIDTH, 16, number of word-address bits in the attached memory; valid word indices are 0 .. 2^MEM_WIDTH-1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  memsizeT: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or illegal size.
- resp_rdata  out  32  load result, valid with resp_valid on a successful load.
- dwe  out  1  memory write enable.
- daddr  out  32  memory word index, equal to req_addr[31:2].
- ddatain  out  32  memory write word.
- ddataout  in  32  memory read word, valid the cycle after daddr is sampled.

## Operation
- States: IDLE, RD_ISSUE, RD_DATA, WR, ERR.
- IDLE:
  - req_ready = 1 and not rst.
  - The unit latches addr, size, we, unsigned and wdata on req_valid && req_ready.
  - Error if any of: size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr[31:2] >= 2^MEM_WIDTH. An error goes to ERR.
  - A word store goes to WR.
  - All other requests go to RD_ISSUE.
- RD_ISSUE: daddr = latched index and dwe = 0. Next state is RD_DATA.
- RD_DATA:
  - Load: extract the lane from ddataout and extend it. Assert resp_valid. Next state is IDLE.
  - Sub-word store: merge req_wdata into ddataout at the lane, register the merged word, then go to WR.
- WR: dwe = 1, daddr = index, ddatain = merged word or req_wdata. Assert resp_valid. Next state is IDLE.
- ERR: resp_valid = 1, resp_err = 1, dwe = 0. Next state is IDLE. Memory is never touched on an error.
- Lanes are little-endian:
  - Byte lane is addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane is addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Sign extension copies the top bit of the selected lane. A word load ignores req_unsigned.
- Outside WR, dwe = 0 and ddatain = 0. resp_rdata = 0 whenever the cycle is not a load response.
- Only one request is in flight; req_ready = 0 in every state except IDLE.

## Timing
- The cycle in which a request is accepted is cycle 0. resp_valid rises in:
  - load: cycle 2.
  - sub-word store: cycle 3 (dwe high only in cycle 3).
  - word store: cycle 1 (dwe high only in cycle 1).
  - error: cycle 1.
- req_ready returns to 1 in the cycle after resp_valid. Back-to-back accepts are not possible.
- Reset values: state IDLE, dwe 0, daddr 0, ddatain 0, resp_valid 0, resp_err 0, resp_rdata 0, req_ready 0 while rst is high.
- Reset mid-operation: rst takes effect immediately and asynchronously. dwe drops in the same cycle, the pending write is abandoned and no response is produced.
- All outputs come from registered state plus latched request fields. The only combinational path from inputs is resp_rdata from ddataout in RD_DATA. No output depends combinationally on req_*.

## Structure
- Add to package types:
  - memsizeT enum {MEM_B=2'b00, MEM_H=2'b01, MEM_W=2'b10}.
  - lsu_stateT enum for the five states.
- Reuse rvwordT from types for all 32-bit data and address signals.
- Sub-module mem_lane_align, purely combinational:
  - inputs: word, lane addr[1:0], size, unsigned, wdata.
  - outputs: extracted/extended load value and merged store word.

## Test plan
Preload memory word index 0x100 (byte address 0x400) = 0x8899AABB; MEM_WIDTH=16.
- Signed byte load at 0x401 -> resp_rdata 0xFFFFFFAA in cycle 2, resp_err 0, dwe never high.
- Unsigned half load at 0x402 -> resp_rdata 0x00008899 in cycle 2.
- Byte store of 0x55 at 0x403 -> daddr 0x100 in cycles 1 and 3, dwe high only in cycle 3 with ddatain 0x5599AABB, resp_valid in cycle 3; a following word load returns 0x5599AABB.
- Word store of 0x12345678 at 0x404 -> dwe high in cycle 1 only, daddr 0x101, ddatain 0x12345678, resp_valid in cycle 1.
- Each of the following -> resp_valid and resp_err in cycle 1, dwe never high:
  - half load at 0x401;
  - word store at 0x402;
  - size 11;
  - load at 0x40000.
- Assert rst during RD_DATA of a byte store -> dwe low throughout, word 0x100 unchanged, req_ready 1 in the first cycle after rst falls.
